mmio_gpio: RTL and testbench
============================

Name: mmio_gpio

Overview:
Parametrised successor to the fixed 4-LED/4-button/4-switch MMIO peripheral. It sits behind the BIU MMIO port (valid/addr/wmask/wdata/rdata) and provides configurable-width LED outputs with atomic set/clear. Button and switch inputs are synchronised and debounced, and button edges are latched into a W1C status register that drives a level interrupt to the core.

Parameters:
LED_W, 4, LED output width (1-32)
BTN_W, 4, button input width (1-32)
SW_W, 4, switch input width (1-32)
DB_CYCLES, 1000, cycles an input must be stable before the debounced value updates; 0 = bypass debounce (sync only)
DB_CNT_W, 16, debounce counter width; must hold DB_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
mmio_i_valid  in  1  access strobe from BIU
mmio_i_addr  in  32  byte address; only addr[4:2] decoded (BIU does region decode)
mmio_i_wmask  in  4  byte write mask; 0 = read
mmio_i_wdata  in  32  write data
mmio_o_rdata  out  32  registered read data
mmio_o_gpio_led  out  LED_W  LED drive
mmio_i_gpio_btn  in  BTN_W  raw buttons (async)
mmio_i_gpio_sw  in  SW_W  raw switches (async)
mmio_o_irq  out  1  level interrupt

Behaviour:
- Register map (addr[4:2]). Unused upper bits read 0. Writes to RO/reserved words are ignored.
  - 0 LED (RW)
  - 1 LED_SET (W1S, reads 0)
  - 2 LED_CLR (W1C, reads 0)
  - 3 BTN (RO, debounced)
  - 4 SW (RO, debounced)
  - 5 EDGE (W1C, rising edges of debounced BTN)
  - 6 IRQ_EN (RW, BTN_W bits)
  - 7 reserved (reads 0)
- Reset (rst low, async): led=0, IRQ_EN=0, EDGE=0, rdata=0, irq=0, sync flops=0, debounced values=0, counters=0.
- Write: when valid && wmask!=0, commits at the rising edge, per byte lane. Only lanes with wmask[i]=1 affect bits [8i+7:8i]; bits beyond the register width are dropped.
- Read: when valid && wmask==0, rdata updates at the next edge, giving 1-cycle latency. rdata holds its value until the next read and does not change on writes or idle cycles.
- Reading EDGE is non-destructive.
- Input path: 2-flop synchroniser per bit, then a per-bit debouncer.
  - The counter resets to 0 whenever the synced bit equals the debounced bit.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, the debounced bit takes the synced value and the counter clears.
  - Raw-to-debounced latency is therefore 2 + DB_CYCLES cycles.
  - DB_CYCLES=0: debounced = synced, latency 2 cycles.
- Edge detect: EDGE[i] sets for one rising 0->1 transition of debounced BTN[i] and stays set until cleared. Falling edges are ignored.
- Same-cycle EDGE set and W1C clear on the same bit: set wins.
- irq = registered |(EDGE & IRQ_EN), so it asserts 1 cycle after the EDGE bit sets.
- Glitch shorter than DB_CYCLES: no change to BTN or EDGE.
- Reset asserted mid-operation clears all state immediately, including pending counters. After release, nothing updates until inputs are stable for the full debounce period.

Test Plan:
- Reset then read: rst low for 3 cycles, read each of words 0-7 -> all rdata=0, led=0, irq=0.
- LED byte masks and atomics (LED_W=16):
  - write LED=0x0000A5C3 with wmask=0001 -> led=0x00C3
  - write LED_SET=0x0F00, wmask=1111 -> led=0x0FC3
  - write LED_CLR=0x00C0 -> led=0x0F03
  - read LED -> 0x00000F03 one cycle after valid.
- Debounce (DB_CYCLES=8): btn[0] toggles 1 for 5 cycles then 0 -> BTN stays 0, EDGE=0. Hold btn[0]=1 -> BTN reads 0x1 exactly 10 cycles after the raw rise.
- Edge/irq: IRQ_EN=0x1, debounced press on btn[0] -> EDGE=0x1 and irq=1 one cycle later. Write EDGE=0x1 -> irq=0. A second press -> irq=1 again.
- Set-wins race: schedule an EDGE W1C write on the exact cycle the debounced btn[1] rises -> EDGE[1]=1 afterwards.
- Async reset mid-debounce: assert rst while a btn counter is at 5 -> counter, BTN and EDGE clear immediately. After release with btn still held, BTN=1 only after the full 2+DB_CYCLES cycles.

Source files
------------

// File: rtl/mmio_gpio.sv
// MMIO GPIO block: LED outputs with atomic set/clear, synchronised and debounced
// buttons/switches, W1C button-edge status and a level interrupt.
module mmio_gpio #(
  parameter int unsigned LED_W     = 4,
  parameter int unsigned BTN_W     = 4,
  parameter int unsigned SW_W      = 4,
  parameter int unsigned DB_CYCLES = 1000,
  parameter int unsigned DB_CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmio_i_valid,
  input  logic [31:0]      mmio_i_addr,
  input  logic [3:0]       mmio_i_wmask,
  input  logic [31:0]      mmio_i_wdata,
  output logic [31:0]      mmio_o_rdata,
  output logic [LED_W-1:0] mmio_o_gpio_led,
  input  logic [BTN_W-1:0] mmio_i_gpio_btn,
  input  logic [SW_W-1:0]  mmio_i_gpio_sw,
  output logic             mmio_o_irq
);

  localparam int unsigned InW = BTN_W + SW_W;

  typedef enum logic [2:0] {
    AddrLed    = 3'd0,
    AddrLedSet = 3'd1,
    AddrLedClr = 3'd2,
    AddrBtn    = 3'd3,
    AddrSw     = 3'd4,
    AddrEdge   = 3'd5,
    AddrIrqEn  = 3'd6,
    AddrRsvd   = 3'd7
  } addr_e;

  // ---------------------------------------------------------------------------
  // Input path: buttons and switches share one synchroniser/debouncer array,
  // buttons in the low bits.
  // ---------------------------------------------------------------------------
  logic [InW-1:0] raw;
  logic [InW-1:0] deb_q, deb_d;

  assign raw = {mmio_i_gpio_sw, mmio_i_gpio_btn};

  for (genvar i = 0; i < InW; i++) begin : g_in
    logic sync1_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q <= 1'b0;
      end else begin
        sync1_q <= raw[i];
      end
    end

    if (DB_CYCLES == 0) begin : g_bypass
      // The debounced flop acts as the second synchroniser stage.
      assign deb_d[i] = sync1_q;
    end else begin : g_debounce
      localparam logic [DB_CNT_W-1:0] DbLast = DB_CNT_W'(DB_CYCLES - 1);

      logic                sync2_q;
      logic [DB_CNT_W-1:0] cnt_q, cnt_d;
      logic                deb_nxt;

      always_comb begin
        cnt_d   = cnt_q;
        deb_nxt = deb_q[i];
        if (sync2_q == deb_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == DbLast) begin
          deb_nxt = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      assign deb_d[i] = deb_nxt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync2_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync2_q <= sync1_q;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end

  // Rising edge seen on the same cycle the debounced button bit goes high.
  logic [BTN_W-1:0] btn_rise;
  assign btn_rise = deb_d[BTN_W-1:0] & ~deb_q[BTN_W-1:0];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic             wr_en, rd_en;
  addr_e            addr_sel;
  logic [31:0]      bmask, wbits;
  logic [LED_W-1:0] led_q, led_d;
  logic [BTN_W-1:0] irq_en_q, irq_en_d;
  logic [BTN_W-1:0] edge_q, edge_d, edge_clr;
  logic [31:0]      rdata_q, rd_word;
  logic             irq_q;

  assign wr_en    = mmio_i_valid && (mmio_i_wmask != 4'b0000);
  assign rd_en    = mmio_i_valid && (mmio_i_wmask == 4'b0000);
  assign addr_sel = addr_e'(mmio_i_addr[4:2]);
  assign bmask    = {{8{mmio_i_wmask[3]}}, {8{mmio_i_wmask[2]}},
                     {8{mmio_i_wmask[1]}}, {8{mmio_i_wmask[0]}}};
  assign wbits    = mmio_i_wdata & bmask;

  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;
    if (wr_en) begin
      case (addr_sel)
        AddrLed:    led_d    = (led_q & ~bmask[LED_W-1:0]) | wbits[LED_W-1:0];
        AddrLedSet: led_d    = led_q | wbits[LED_W-1:0];
        AddrLedClr: led_d    = led_q & ~wbits[LED_W-1:0];
        AddrEdge:   edge_clr = wbits[BTN_W-1:0];
        AddrIrqEn:  irq_en_d = (irq_en_q & ~bmask[BTN_W-1:0]) | wbits[BTN_W-1:0];
        default:    ;
      endcase
    end
    // A new edge beats a simultaneous W1C so no press is ever lost.
    edge_d = (edge_q & ~edge_clr) | btn_rise;
  end

  always_comb begin
    rd_word = '0;
    case (addr_sel)
      AddrLed:   rd_word = 32'(led_q);
      AddrBtn:   rd_word = 32'(deb_q[BTN_W-1:0]);
      AddrSw:    rd_word = 32'(deb_q[InW-1:BTN_W]);
      AddrEdge:  rd_word = 32'(edge_q);
      AddrIrqEn: rd_word = 32'(irq_en_q);
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q    <= '0;
      irq_en_q <= '0;
      edge_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      irq_en_q <= irq_en_d;
      edge_q   <= edge_d;
      irq_q    <= |(edge_q & irq_en_q);
      if (rd_en) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign mmio_o_rdata    = rdata_q;
  assign mmio_o_gpio_led = led_q;
  assign mmio_o_irq      = irq_q;

  logic unused_bits;
  assign unused_bits = ^{mmio_i_addr[31:5], mmio_i_addr[1:0], wbits};

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio: register map, LED atomics, debounce timing,
// edge/irq behaviour, set-wins race and asynchronous reset mid-debounce.
module tb_mmio_gpio;

  localparam int unsigned LED_W = 16;
  localparam int unsigned BTN_W = 4;
  localparam int unsigned SW_W  = 4;
  localparam int unsigned DB    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic [31:0]      addr;
  logic [3:0]       wmask;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [LED_W-1:0] led;
  logic [BTN_W-1:0] btn;
  logic [SW_W-1:0]  sw;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] d;

  mmio_gpio #(
    .LED_W    (LED_W),
    .BTN_W    (BTN_W),
    .SW_W     (SW_W),
    .DB_CYCLES(DB),
    .DB_CNT_W (16)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .mmio_i_valid   (valid),
    .mmio_i_addr    (addr),
    .mmio_i_wmask   (wmask),
    .mmio_i_wdata   (wdata),
    .mmio_o_rdata   (rdata),
    .mmio_o_gpio_led(led),
    .mmio_i_gpio_btn(btn),
    .mmio_i_gpio_sw (sw),
    .mmio_o_irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int word, input logic [3:0] m, input logic [31:0] data);
    valid = 1'b1;
    addr  = 32'(word) << 2;
    wmask = m;
    wdata = data;
    tick();
    valid = 1'b0;
    wmask = 4'b0000;
  endtask

  task automatic rd(input int word, output logic [31:0] data);
    valid = 1'b1;
    addr  = 32'(word) << 2;
    wmask = 4'b0000;
    tick();
    valid = 1'b0;
    data  = rdata;
  endtask

  // Raw inputs are driven right after an edge; the debounced value changes
  // at edge 2+DB, so a BTN read held every cycle shows it one edge later.
  task automatic btn_timing(input string tag, input logic [31:0] exp);
    valid = 1'b1;
    addr  = 32'(3) << 2;
    wmask = 4'b0000;
    for (int k = 1; k <= DB + 3; k++) begin
      tick();
      if (k == DB + 2) check({tag, "_early"}, rdata, 32'h0);
      if (k == DB + 3) check({tag, "_on"}, rdata, exp);
    end
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    addr  = '0;
    wmask = '0;
    wdata = '0;
    btn   = '0;
    sw    = '0;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    tick();

    for (int w = 0; w < 8; w++) begin
      rd(w, d);
      check($sformatf("rst_word%0d", w), d, 32'h0);
    end

    // LED byte lanes and atomics
    wr(0, 4'b0001, 32'h0000_A5C3);
    check("led_lane0", 32'(led), 32'h0000_00C3);
    wr(1, 4'b1111, 32'h0000_0F00);
    check("led_set", 32'(led), 32'h0000_0FC3);
    wr(2, 4'b1111, 32'h0000_00C0);
    check("led_clr", 32'(led), 32'h0000_0F03);
    rd(0, d);
    check("led_read", d, 32'h0000_0F03);
    wr(0, 4'b0010, 32'h0000_5A77);
    check("led_lane1", 32'(led), 32'h0000_5A03);
    wr(0, 4'b1111, 32'hFFFF_1234);
    check("led_trunc", 32'(led), 32'h0000_1234);
    rd(0, d);
    check("led_read2", d, 32'h0000_1234);
    wr(1, 4'b1111, 32'h0000_0001);
    tick();
    check("rdata_hold", rdata, 32'h0000_1234);
    rd(1, d);
    check("ledset_reads0", d, 32'h0);
    rd(2, d);
    check("ledclr_reads0", d, 32'h0);
    wr(3, 4'b1111, 32'hFFFF_FFFF);
    rd(3, d);
    check("btn_ro", d, 32'h0);
    wr(6, 4'b1111, 32'hFFFF_FFFF);
    rd(6, d);
    check("irqen_width", d, 32'h0000_000F);
    wr(6, 4'b1111, 32'h0000_0001);
    rd(7, d);
    check("rsvd_reads0", d, 32'h0);

    // Switches
    sw = 4'b1010;
    repeat (DB + 4) tick();
    rd(4, d);
    check("sw_read", d, 32'h0000_000A);

    // Short glitch must not pass the debouncer
    btn[0] = 1'b1;
    repeat (5) tick();
    btn[0] = 1'b0;
    repeat (DB + 6) tick();
    rd(3, d);
    check("glitch_btn", d, 32'h0);
    rd(5, d);
    check("glitch_edge", d, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);

    // Full press: BTN timing, EDGE and irq one cycle after
    btn[0] = 1'b1;
    valid  = 1'b1;
    addr   = 32'(3) << 2;
    wmask  = 4'b0000;
    for (int k = 1; k <= DB + 3; k++) begin
      tick();
      if (k == DB + 2) begin
        check("press_btn_early", rdata, 32'h0);
        check("press_irq_early", 32'(irq), 32'h0);
      end
      if (k == DB + 3) begin
        check("press_btn_on", rdata, 32'h1);
        check("press_irq_on", 32'(irq), 32'h1);
      end
    end
    valid = 1'b0;
    rd(5, d);
    check("press_edge", d, 32'h1);
    rd(5, d);
    check("edge_nondestructive", d, 32'h1);

    wr(5, 4'b1111, 32'h0000_0001);
    tick();
    check("w1c_irq", 32'(irq), 32'h0);
    rd(5, d);
    check("w1c_edge", d, 32'h0);

    btn[0] = 1'b0;
    repeat (DB + 4) tick();
    rd(5, d);
    check("fall_ignored", d, 32'h0);
    btn[0] = 1'b1;
    repeat (DB + 4) tick();
    check("press2_irq", 32'(irq), 32'h1);

    // Set-wins race: W1C of bit 1 commits on the edge the debounced bit rises
    wr(5, 4'b1111, 32'h0000_0001);
    btn[1] = 1'b1;
    repeat (DB + 1) tick();
    wr(5, 4'b1111, 32'h0000_0002);
    rd(5, d);
    check("race_set_wins", d, 32'h0000_0002);
    wr(5, 4'b1111, 32'h0000_0002);
    rd(5, d);
    check("race_later_clear", d, 32'h0);

    // Async reset with a counter mid-count
    btn = 4'b0000;
    repeat (DB + 4) tick();
    wr(0, 4'b1111, 32'h0000_00FF);
    rd(0, d);
    btn[2] = 1'b1;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    tick();
    rst = 1'b1;
    btn_timing("arst_btn", 32'h0000_0004);
    rd(5, d);
    check("arst_edge", d, 32'h0000_0004);
    rd(6, d);
    check("arst_irqen", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
